// File: rtl/gpr_write_back_scheduler.sv
// gpr_write_back_scheduler
// Round-robin arbiter that shares the single GPR write-back port among
// NUM_REQ execution units, with one registered valid/ready output stage.
// Optional statistics counters are built only when WB_SCHED_STATS_EN is
// defined; otherwise grant_count/stall_count are tied to zero.

module gpr_write_back_scheduler #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned RS_ID_WIDTH = 5,
    parameter int unsigned CNT_WIDTH   = 16,
    localparam int unsigned SRC_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic [NUM_REQ-1:0]                  in_valid,
    output logic [NUM_REQ-1:0]                  in_ready,
    input  logic [NUM_REQ-1:0][RS_ID_WIDTH-1:0] in_rs_id,
    input  logic [NUM_REQ-1:0][4:0]             in_reg_addr,
    input  logic [NUM_REQ-1:0][31:0]            in_result,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [RS_ID_WIDTH-1:0]              out_rs_id,
    output logic [4:0]                          out_reg_addr,
    output logic [31:0]                         out_result,
    output logic [SRC_WIDTH-1:0]                out_src,
    output logic [NUM_REQ-1:0][CNT_WIDTH-1:0]   grant_count,
    output logic [CNT_WIDTH-1:0]                stall_count
);

    logic [SRC_WIDTH-1:0] ptr;
    logic [SRC_WIDTH-1:0] ptr_next;
    logic [SRC_WIDTH-1:0] grant_idx;
    logic                 grant_valid;
    logic                 load_en;
    logic                 transfer;

    // Output register may load when empty or draining this cycle
    assign load_en  = ~rst & ~flush & (~out_valid | out_ready);
    assign transfer = grant_valid & load_en;

    // Round-robin search starting at the pointer; first valid requester wins
    always_comb begin
        logic [SRC_WIDTH-1:0] cand;
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int j = 0; j < int'(NUM_REQ); j++) begin
            cand = SRC_WIDTH'((32'(ptr) + 32'(j)) % NUM_REQ);
            if (!grant_valid && in_valid[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Only the granted requester sees ready, and only when the stage can load
    always_comb begin
        in_ready = '0;
        if (grant_valid) begin
            in_ready[grant_idx] = load_en;
        end
    end

    // Pointer advances past the winner with an explicit wrap (non power-of-2 safe)
    always_comb begin
        if (grant_idx == SRC_WIDTH'(NUM_REQ - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = grant_idx + SRC_WIDTH'(1);
        end
    end

    // Pointer register
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (transfer) begin
            ptr <= ptr_next;
        end
    end

    // Output stage: flush drops, transfer captures, drain clears valid, stall holds
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_rs_id    <= '0;
            out_reg_addr <= '0;
            out_result   <= '0;
            out_src      <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (transfer) begin
            out_valid    <= 1'b1;
            out_rs_id    <= in_rs_id[grant_idx];
            out_reg_addr <= in_reg_addr[grant_idx];
            out_result   <= in_result[grant_idx];
            out_src      <= grant_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef WB_SCHED_STATS_EN
    logic [NUM_REQ-1:0][CNT_WIDTH-1:0] grant_cnt;
    logic [CNT_WIDTH-1:0]              stall_cnt;

    // Saturating per-requester grant counters and back-pressure counter
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (transfer && (grant_idx == SRC_WIDTH'(i)) && (grant_cnt[i] != '1)) begin
                    grant_cnt[i] <= grant_cnt[i] + CNT_WIDTH'(1);
                end
            end
            if (out_valid && !out_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign grant_count = grant_cnt;
    assign stall_count = stall_cnt;
`else
    assign grant_count = '0;
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_gpr_write_back_scheduler.sv
// Directed self-checking bench for gpr_write_back_scheduler.
// Main instance uses NUM_REQ=4; a second instance with NUM_REQ=3 covers wrap.

module tb_gpr_write_back_scheduler;

`ifdef WB_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  flush;

    logic [3:0]            in_valid;
    logic [3:0]            in_ready;
    logic [3:0][4:0]       in_rs_id;
    logic [3:0][4:0]       in_reg_addr;
    logic [3:0][31:0]      in_result;
    logic                  out_valid;
    logic                  out_ready;
    logic [4:0]            out_rs_id;
    logic [4:0]            out_reg_addr;
    logic [31:0]           out_result;
    logic [1:0]            out_src;
    logic [3:0][15:0]      grant_count;
    logic [15:0]           stall_count;

    logic [2:0]            in_valid3;
    logic [2:0]            in_ready3;
    logic [2:0][4:0]       in_rs_id3;
    logic [2:0][4:0]       in_reg_addr3;
    logic [2:0][31:0]      in_result3;
    logic                  out_valid3;
    logic                  out_ready3;
    logic [4:0]            out_rs_id3;
    logic [4:0]            out_reg_addr3;
    logic [31:0]           out_result3;
    logic [1:0]            out_src3;
    logic [2:0][15:0]      grant_count3;
    logic [15:0]           stall_count3;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    gpr_write_back_scheduler #(.NUM_REQ(4), .RS_ID_WIDTH(5), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_rs_id(in_rs_id),
        .in_reg_addr(in_reg_addr), .in_result(in_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_rs_id(out_rs_id),
        .out_reg_addr(out_reg_addr), .out_result(out_result), .out_src(out_src),
        .grant_count(grant_count), .stall_count(stall_count)
    );

    gpr_write_back_scheduler #(.NUM_REQ(3), .RS_ID_WIDTH(5), .CNT_WIDTH(16)) dut3 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_rs_id(in_rs_id3),
        .in_reg_addr(in_reg_addr3), .in_result(in_result3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_rs_id(out_rs_id3),
        .out_reg_addr(out_reg_addr3), .out_result(out_result3), .out_src(out_src3),
        .grant_count(grant_count3), .stall_count(stall_count3)
    );

    // Advance one clock and settle 1 time unit past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush = 1'b0;
        in_valid = '0;
        in_valid3 = '0;
        out_ready = 1'b1;
        out_ready3 = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 4'b1111;
        tick();
        vectors++;
        if (in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 0000", in_ready);
        end
        vectors++;
        if ({out_valid, out_rs_id, out_reg_addr, out_result, out_src} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b id=%h reg=%h res=%h src=%h expected all 0",
                     out_valid, out_rs_id, out_reg_addr, out_result, out_src);
        end
        vectors++;
        if (grant_count !== '0 || stall_count !== '0) begin
            errors++;
            $display("FAIL reset_counters: got gc=%h sc=%h expected 0", grant_count, stall_count);
        end
        vectors++;
        if (dut.ptr !== 2'd0) begin
            errors++;
            $display("FAIL reset_ptr: got %0d expected 0", dut.ptr);
        end
    endtask

    task automatic test_round_robin();
        int s;
        do_reset();
        in_valid = 4'b1111;
        out_ready = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rr_latency: got out_valid=%b expected 0 before first edge", out_valid);
        end
        for (int k = 0; k < 6; k++) begin
            s = k % 4;
            vectors++;
            if (in_ready !== 4'(1 << s)) begin
                errors++;
                $display("FAIL rr_in_ready[%0d]: got %b expected %b", k, in_ready, 4'(1 << s));
            end
            tick();
            vectors++;
            if (out_valid !== 1'b1 || out_src !== 2'(s) || out_result !== 32'h1000_0000 + 32'(s)
                || out_reg_addr !== 5'(s + 1) || out_rs_id !== 5'(s + 10)) begin
                errors++;
                $display("FAIL rr_out[%0d]: got v=%b src=%0d res=%h reg=%0d id=%0d expected src=%0d",
                         k, out_valid, out_src, out_result, out_reg_addr, out_rs_id, s);
            end
        end
        vectors++;
        if (grant_count[0] !== (STATS ? 16'd2 : 16'd0) || grant_count[3] !== (STATS ? 16'd1 : 16'd0)) begin
            errors++;
            $display("FAIL rr_grant_count: got g0=%0d g3=%0d", grant_count[0], grant_count[3]);
        end
        in_valid = '0;
        tick();
        vectors++;
        if (out_valid !== 1'b0 || out_src !== 2'd1) begin
            errors++;
            $display("FAIL rr_drain: got v=%b src=%0d expected v=0 src=1 held", out_valid, out_src);
        end
    endtask

    task automatic test_single_requester();
        do_reset();
        in_result[2] = 32'hDEAD_BEEF;
        in_reg_addr[2] = 5'd7;
        in_rs_id[2] = 5'd3;
        in_valid = 4'b0100;
        #1;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (in_ready !== 4'b0100) begin
                errors++;
                $display("FAIL single_in_ready[%0d]: got %b expected 0100", k, in_ready);
            end
            tick();
            vectors++;
            if (out_valid !== 1'b1 || out_result !== 32'hDEAD_BEEF || out_reg_addr !== 5'd7
                || out_rs_id !== 5'd3 || out_src !== 2'd2 || dut.ptr !== 2'd3) begin
                errors++;
                $display("FAIL single_out[%0d]: got v=%b res=%h reg=%0d id=%0d src=%0d ptr=%0d",
                         k, out_valid, out_result, out_reg_addr, out_rs_id, out_src, dut.ptr);
            end
        end
        in_result[2] = 32'h1000_0002;
        in_reg_addr[2] = 5'd3;
        in_rs_id[2] = 5'd12;
    endtask

    task automatic test_stall();
        do_reset();
        in_valid = 4'b0011;
        out_ready = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (in_ready !== 4'b0000) begin
                errors++;
                $display("FAIL stall_in_ready[%0d]: got %b expected 0000", k, in_ready);
            end
            tick();
            vectors++;
            if (out_valid !== 1'b1 || out_src !== 2'd0 || out_result !== 32'h1000_0000) begin
                errors++;
                $display("FAIL stall_frozen[%0d]: got v=%b src=%0d res=%h expected v=1 src=0",
                         k, out_valid, out_src, out_result);
            end
        end
        vectors++;
        if (stall_count !== (STATS ? 16'd3 : 16'd0)) begin
            errors++;
            $display("FAIL stall_count: got %0d expected %0d", stall_count, STATS ? 3 : 0);
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 4'b0010) begin
            errors++;
            $display("FAIL stall_release_ready: got %b expected 0010", in_ready);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_src !== 2'd1 || out_result !== 32'h1000_0001) begin
            errors++;
            $display("FAIL stall_release_out: got v=%b src=%0d res=%h expected src=1",
                     out_valid, out_src, out_result);
        end
    endtask

    task automatic test_flush();
        do_reset();
        in_valid = 4'b0011;
        out_ready = 1'b0;
        tick();
        flush = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL flush_in_ready: got %b expected 0000", in_ready);
        end
        tick();
        flush = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || dut.ptr !== 2'd1) begin
            errors++;
            $display("FAIL flush_out: got v=%b ptr=%0d expected v=0 ptr=1", out_valid, dut.ptr);
        end
        vectors++;
        if (grant_count[0] !== (STATS ? 16'd1 : 16'd0) || grant_count[1] !== 16'd0) begin
            errors++;
            $display("FAIL flush_grant_count: got g0=%0d g1=%0d", grant_count[0], grant_count[1]);
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 4'b0010) begin
            errors++;
            $display("FAIL flush_resume_ready: got %b expected 0010", in_ready);
        end
    endtask

    task automatic test_wrap3();
        do_reset();
        in_valid3 = 3'b100;
        #1;
        vectors++;
        if (in_ready3 !== 3'b100) begin
            errors++;
            $display("FAIL wrap3_ready_a: got %b expected 100", in_ready3);
        end
        tick();
        vectors++;
        if (out_valid3 !== 1'b1 || out_src3 !== 2'd2 || out_result3 !== 32'h3000_0002
            || dut3.ptr !== 2'd0) begin
            errors++;
            $display("FAIL wrap3_out_a: got v=%b src=%0d res=%h ptr=%0d expected src=2 ptr=0",
                     out_valid3, out_src3, out_result3, dut3.ptr);
        end
        in_valid3 = 3'b101;
        #1;
        vectors++;
        if (in_ready3 !== 3'b001) begin
            errors++;
            $display("FAIL wrap3_ready_b: got %b expected 001", in_ready3);
        end
        tick();
        vectors++;
        if (out_src3 !== 2'd0 || out_result3 !== 32'h3000_0000 || dut3.ptr !== 2'd1) begin
            errors++;
            $display("FAIL wrap3_out_b: got src=%0d res=%h ptr=%0d expected src=0 ptr=1",
                     out_src3, out_result3, dut3.ptr);
        end
        in_valid3 = '0;
    endtask

    task automatic test_reset_mid_stream();
        do_reset();
        in_valid = 4'b1111;
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL rstmid_in_ready: got %b expected 0000", in_ready);
        end
        tick();
        vectors++;
        if ({out_valid, out_rs_id, out_reg_addr, out_result, out_src} !== '0 || dut.ptr !== 2'd0) begin
            errors++;
            $display("FAIL rstmid_outputs: got v=%b src=%0d res=%h ptr=%0d expected all 0",
                     out_valid, out_src, out_result, dut.ptr);
        end
        vectors++;
        if (grant_count !== '0 || stall_count !== '0 || in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL rstmid_counters: got gc=%h sc=%0d rdy=%b expected 0",
                     grant_count, stall_count, in_ready);
        end
        rst = 1'b0;
        in_valid = '0;
        out_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        in_valid = '0;
        in_valid3 = '0;
        out_ready = 1'b1;
        out_ready3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_result[i]   = 32'h1000_0000 + 32'(i);
            in_reg_addr[i] = 5'(i + 1);
            in_rs_id[i]    = 5'(i + 10);
        end
        for (int i = 0; i < 3; i++) begin
            in_result3[i]   = 32'h3000_0000 + 32'(i);
            in_reg_addr3[i] = 5'(i + 20);
            in_rs_id3[i]    = 5'(i + 1);
        end

        test_reset();
        test_round_robin();
        test_single_requester();
        test_stall();
        test_flush();
        test_wrap3();
        test_reset_mid_stream();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/gpr_write_back_scheduler.md
Name: gpr_write_back_scheduler

Overview:
Shares the single GPR write-back port among NUM_REQ execution units, e.g. ALU, mul/div and load/store.
- Arbitration is round-robin.
- One registered output stage, driven with a valid/ready handshake toward the write-back arbiter/register file.
- Accepts one result per cycle at full throughput.
- Supports pipeline flush.

Parameters:
NUM_REQ, 4, number of requesting execution units (1..16).
RS_ID_WIDTH, 5, width of reservation-station tag.
CNT_WIDTH, 16, width of statistics counters (only used with WB_SCHED_STATS_EN).

Ports:
clk  in  1  clock.
rst  in  1  reset, synchronous, active-high.
flush  in  1  synchronous flush; discards held result.
in_valid  in  [NUM_REQ]  requester i has a result.
in_ready  out  [NUM_REQ]  requester i result accepted this cycle.
in_rs_id  in  [NUM_REQ] x RS_ID_WIDTH  tag per requester.
in_reg_addr  in  [NUM_REQ] x 5  destination GPR per requester.
in_result  in  [NUM_REQ] x 32  result per requester.
out_valid  out  1  held result valid.
out_ready  in  1  downstream accepts held result.
out_rs_id  out  RS_ID_WIDTH  tag of held result.
out_reg_addr  out  5  destination GPR of held result.
out_result  out  32  held result.
out_src  out  clog2(NUM_REQ) (min 1)  index of requester that produced held result.
grant_count  out  [NUM_REQ] x CNT_WIDTH  per-requester accepted count (macro only).
stall_count  out  CNT_WIDTH  back-pressure cycles (macro only).

Behaviour:
- Reset values:
  - out_valid=0; out_rs_id, out_reg_addr, out_result, out_src=0.
  - pointer=0.
  - Counters=0.
  - in_ready all 0 while rst=1.
- load_en = ~rst & ~flush & (~out_valid | out_ready).
- Grant search, combinational:
  - Scan j=0..NUM_REQ-1 over index (pointer+j) mod NUM_REQ.
  - The first asserted in_valid wins and is called g.
  - No valid input means no grant.
- in_ready[g] = load_en. All other in_ready = 0. in_ready does not depend on other requesters' ready.
- Transfer when in_valid[g] & in_ready[g]. On the next edge:
  - Output register captures rs_id/reg_addr/result of g, sets out_src=g, out_valid=1.
  - pointer <= (g+1) mod NUM_REQ.
- Pointer is unchanged when no transfer happens.
- Latency: input accept to out_valid is 1 cycle.
- Throughput: 1 result/cycle while out_ready=1.
- If out_valid & out_ready and no transfer: out_valid <= 0; data fields hold their last value.
- If out_valid & ~out_ready: output stays fixed, all in_ready=0. Stable-while-stalled is required.
- Simultaneous drain and accept in the same cycle is allowed. This is the full-throughput path.
- flush:
  - out_valid <= 0 next edge, in_ready all 0 that cycle.
  - pointer is unchanged; no new result is captured.
  - flush overrides out_ready.
- rst takes priority over flush.
- Reset mid-stall drops the held result.
- NUM_REQ=1: pointer is constant 0 and out_src is 0.
- NUM_REQ not a power of 2: the wrap uses explicit modulo; the pointer never holds a value >= NUM_REQ.
- Duplicate reg_addr across requesters is not checked. Ordering is purely by grant order.

Optional Feature:
WB_SCHED_STATS_EN
- Defined:
  - grant_count[i] increments on each transfer from requester i.
  - stall_count increments each cycle out_valid & ~out_ready.
  - All counters saturate at 2^CNT_WIDTH-1, are cleared by rst, and are not affected by flush.
- Undefined: grant_count and stall_count are tied to 0 and no counter flops exist.

Test Plan:
1. All four requesters valid continuously, out_ready=1 from reset -> out_src sequence 0,1,2,3,0,1; one in_ready per cycle; first out_valid one cycle after first accept.
2. Only req 2 valid (result 0xDEADBEEF, reg 7, tag 3), out_ready=1 -> in_ready[2]=1 each cycle; out_result=0xDEADBEEF, out_reg_addr=7, out_rs_id=3; pointer=3 after each transfer.
3. Req 0 and req 1 valid, out_ready=0 for 3 cycles after first capture -> outputs frozen, in_ready all 0, stall_count=3 (macro on); on out_ready=1, req 1 is accepted next.
4. flush asserted while out_valid=1, out_ready=0 -> next cycle out_valid=0, no in_ready during flush, pointer unchanged, grant_count unchanged.
5. NUM_REQ=3, req 2 granted -> pointer wraps to 0; req 0 and req 2 both valid -> req 0 wins.
6. rst asserted mid-stream with out_valid=1 -> next cycle out_valid=0, all outputs 0, counters 0, pointer 0, in_ready 0 while rst=1.
